// File: rtl/ad_cap_pkg.sv
// ad_cap_pkg: shared types and constants for the AD7606 capture engine.
//   - ad_cap_state_e : capture FSM state encoding
//   - HDR_MAGIC      : marker byte in the top of every frame header word
//   - AD_RST_CYCLES  : cycles ad_reset is held high
//   - BUSY_RISE_TO   : cycles allowed for ad_busy to rise after convst
//   - popcount8()    : number of set bits in an 8-bit channel mask
//   - words_for()    : FIFO words one frame occupies (header + packed pairs)
package ad_cap_pkg;

    typedef enum logic [2:0] {
        ST_AD_RST    = 3'd0,
        ST_IDLE      = 3'd1,
        ST_CONV      = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_WAIT_FALL = 3'd4,
        ST_READ      = 3'd5,
        ST_PACK      = 3'd6
    } ad_cap_state_e;

    localparam logic [7:0] HDR_MAGIC     = 8'hA5;
    localparam int         AD_RST_CYCLES = 4;
    localparam int         BUSY_RISE_TO  = 16;

    function automatic logic [3:0] popcount8(input logic [7:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, m[i]};
        end
        return c;
    endfunction

    // One header word plus one word per pair of samples (odd count rounds up).
    function automatic logic [2:0] words_for(input logic [7:0] mask);
        logic [3:0] n;
        n = popcount8(mask);
        return 3'(4'd1 + ((n + 4'd1) >> 1));
    endfunction

endpackage

// File: rtl/ad_cap_fifo.sv
// ad_cap_fifo: synchronous show-ahead FIFO with a level output.
//   clk, reset_syn    : clock, synchronous active-high reset (empties FIFO)
//   push_i/push_data_i: write one word (ignored when full)
//   pop_i             : consume the word on pop_data_o (ignored when empty)
//   pop_data_o        : head word while valid_o, zero otherwise
//   valid_o           : FIFO holds at least one word
//   level_o           : number of words stored
module ad_cap_fifo #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_syn,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_data_o,
    output logic          valid_o,
    output logic [AW:0]   level_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i && (count_q != (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_syn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o    = (count_q != '0);
    // Gate the head word so the output reads zero while empty.
    assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = count_q;

endmodule

// File: rtl/ad_capture_pack.sv
// ad_capture_pack: AD7606 capture engine with channel masking and framing.
//   Conversion pacing : period counter ticks every CONV_DIV cycles while enable.
//   Converter pins    : ad_os, ad_cs, ad_rd, ad_reset, ad_convstab (outputs),
//                       ad_data, ad_busy, first_data (inputs).
//   Output stream     : m_data/m_valid/m_ready; a word is transferred on a clock
//                       edge where m_valid and m_ready are both high. m_valid
//                       never depends on m_ready and m_data is stable while
//                       m_valid is high and m_ready low.
//   Status            : fifo_level, overflow_cnt (saturating), frame_err (sticky).
//   Debug             : dbg_state_o shows the capture FSM state.
// Frame format: header {A5, seq, mask, n}, then samples of the selected channels
// in ascending order, two per word, earlier sample in [15:0], odd tail padded.
module ad_capture_pack
    import ad_cap_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int FIFO_AW   = 9,
    parameter int CONV_DIV  = 2500,
    parameter int T_RD_LOW  = 3,
    parameter int T_RD_HIGH = 2,
    parameter int BUSY_TO   = 10000
) (
    input  logic                clk,
    input  logic                reset_syn,
    input  logic                enable,
    input  logic [2:0]          os_sel,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [15:0]         ad_data,
    input  logic                ad_busy,
    input  logic                first_data,
    output logic [2:0]          ad_os,
    output logic                ad_cs,
    output logic                ad_rd,
    output logic                ad_reset,
    output logic                ad_convstab,
    output logic [31:0]         m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [FIFO_AW:0]    fifo_level,
    output logic [15:0]         overflow_cnt,
    output logic                frame_err,
    output ad_cap_state_e       dbg_state_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DIVW  = $clog2(CONV_DIV + 1);

    // Period counter
    logic [DIVW-1:0] div_q;
    logic            tick;

    always_ff @(posedge clk) begin
        if (reset_syn || !enable) begin
            div_q <= '0;
        end else if (div_q == DIVW'(CONV_DIV - 1)) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = enable && (div_q == DIVW'(CONV_DIV - 1));

    // FSM state and registered outputs
    ad_cap_state_e state_q;
    logic [15:0]   cnt_q;
    logic [2:0]    ch_q;
    logic [2:0]    wr_idx_q;
    logic [15:0]   samp_q [8];
    logic [7:0]    mask_q;
    logic [3:0]    n_q;
    logic [2:0]    w_q;
    logic [2:0]    pk_q;
    logic [2:0]    reserved_q;
    logic [7:0]    seq_q;
    logic          pend_q;
    logic [2:0]    ad_os_q;
    logic          ad_cs_q;
    logic          ad_rd_q;
    logic          ad_reset_q;
    logic          ad_convstab_q;
    logic [15:0]   ovf_q;
    logic          ferr_q;

    logic [7:0]    mask8_in;
    logic [2:0]    need_w;
    logic          no_room;
    logic          push;
    logic [31:0]   push_data;
    logic [1:0]    pair;
    logic [2:0]    lo_idx;
    logic [2:0]    hi_idx;
    logic [15:0]   hi_samp;

    always_comb begin
        mask8_in = '0;
        mask8_in[NUM_CH-1:0] = ch_mask;
        need_w  = words_for(mask8_in);
        // Space still owed to an in-flight frame counts as used.
        no_room = (int'(fifo_level) + int'(reserved_q) + int'(need_w)) > DEPTH;
    end

    // Packer: word 0 is the header, word k carries compacted samples 2k-2, 2k-1.
    always_comb begin
        push    = (state_q == ST_PACK);
        pair    = 2'(pk_q - 3'd1);
        lo_idx  = {pair, 1'b0};
        hi_idx  = {pair, 1'b1};
        hi_samp = ({1'b0, hi_idx} < n_q) ? samp_q[hi_idx] : 16'h0000;
        if (pk_q == 3'd0) begin
            push_data = {HDR_MAGIC, seq_q, mask_q, 4'h0, n_q};
        end else begin
            push_data = {hi_samp, samp_q[lo_idx]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset_syn) begin
            state_q       <= ST_AD_RST;
            cnt_q         <= '0;
            ch_q          <= '0;
            wr_idx_q      <= '0;
            mask_q        <= '0;
            n_q           <= '0;
            w_q           <= '0;
            pk_q          <= '0;
            reserved_q    <= '0;
            seq_q         <= '0;
            pend_q        <= 1'b0;
            ad_os_q       <= '0;
            ad_cs_q       <= 1'b1;
            ad_rd_q       <= 1'b1;
            ad_reset_q    <= 1'b1;
            ad_convstab_q <= 1'b1;
            ovf_q         <= '0;
            ferr_q        <= 1'b0;
        end else begin
            // A tick that arrives while busy is remembered once; more are lost.
            if (!enable) begin
                pend_q <= 1'b0;
            end else if (tick && (state_q != ST_IDLE)) begin
                pend_q <= 1'b1;
            end

            case (state_q)
                ST_AD_RST: begin
                    ad_reset_q <= 1'b1;
                    if (cnt_q == 16'(AD_RST_CYCLES - 1)) begin
                        cnt_q      <= '0;
                        ad_reset_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_IDLE: begin
                    ad_os_q <= os_sel;
                    if ((tick || pend_q) && enable) begin
                        pend_q <= 1'b0;
                        if (mask8_in != 8'h00) begin
                            if (no_room) begin
                                if (ovf_q != 16'hFFFF) begin
                                    ovf_q <= ovf_q + 16'd1;
                                end
                            end else begin
                                mask_q        <= mask8_in;
                                n_q           <= popcount8(mask8_in);
                                w_q           <= need_w;
                                reserved_q    <= need_w;
                                ad_convstab_q <= 1'b0;
                                cnt_q         <= '0;
                                state_q       <= ST_CONV;
                            end
                        end
                    end
                end

                ST_CONV: begin
                    if (cnt_q == 16'd1) begin
                        ad_convstab_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ST_WAIT_RISE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_WAIT_RISE: begin
                    if (ad_busy) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_FALL;
                    end else if (cnt_q == 16'(BUSY_RISE_TO - 1)) begin
                        ferr_q     <= 1'b1;
                        reserved_q <= '0;
                        ad_reset_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_AD_RST;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_WAIT_FALL: begin
                    if (!ad_busy) begin
                        ad_cs_q  <= 1'b0;
                        ad_rd_q  <= 1'b0;
                        cnt_q    <= '0;
                        ch_q     <= '0;
                        wr_idx_q <= '0;
                        state_q  <= ST_READ;
                    end else if (cnt_q == 16'(BUSY_TO - 1)) begin
                        ferr_q     <= 1'b1;
                        reserved_q <= '0;
                        ad_reset_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_AD_RST;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_READ: begin
                    // cnt_q is the phase within the current channel's rd cycle.
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == 16'(T_RD_LOW - 1)) begin
                        ad_rd_q <= 1'b1;
                        // Selected samples are stored compacted, in channel order.
                        if (mask_q[ch_q]) begin
                            samp_q[wr_idx_q] <= ad_data;
                            wr_idx_q         <= wr_idx_q + 3'd1;
                        end
                        if ((ch_q == 3'd0) && !first_data) begin
                            ferr_q     <= 1'b1;
                            reserved_q <= '0;
                            ad_cs_q    <= 1'b1;
                            ad_rd_q    <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= ST_IDLE;
                        end
                    end
                    if (cnt_q == 16'(T_RD_LOW + T_RD_HIGH - 1)) begin
                        cnt_q <= '0;
                        if (ch_q == 3'(NUM_CH - 1)) begin
                            ad_cs_q <= 1'b1;
                            ad_rd_q <= 1'b1;
                            pk_q    <= '0;
                            state_q <= ST_PACK;
                        end else begin
                            ch_q    <= ch_q + 3'd1;
                            ad_rd_q <= 1'b0;
                        end
                    end
                end

                ST_PACK: begin
                    reserved_q <= reserved_q - 3'd1;
                    pk_q       <= pk_q + 3'd1;
                    if (pk_q == (w_q - 3'd1)) begin
                        seq_q   <= seq_q + 8'd1;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_AD_RST;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    ad_cap_fifo #(
        .AW (FIFO_AW),
        .DW (32)
    ) u_fifo (
        .clk         (clk),
        .reset_syn   (reset_syn),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (m_ready),
        .pop_data_o  (m_data),
        .valid_o     (m_valid),
        .level_o     (fifo_level)
    );

    assign ad_os        = ad_os_q;
    assign ad_cs        = ad_cs_q;
    assign ad_rd        = ad_rd_q;
    assign ad_reset     = ad_reset_q;
    assign ad_convstab  = ad_convstab_q;
    assign overflow_cnt = ovf_q;
    assign frame_err    = ferr_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ad_capture_pack.sv
// Directed bench for ad_capture_pack with a small AD7606 behavioural model
// and an expected-word queue checked on every stream transfer.
module tb_ad_capture_pack;
    import ad_cap_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int FIFO_AW   = 3;
    localparam int CONV_DIV  = 100;
    localparam int T_RD_LOW  = 3;
    localparam int T_RD_HIGH = 2;
    localparam int BUSY_TO   = 50;

    // Clock / reset
    logic clk = 1'b0;
    logic reset_syn = 1'b1;
    always #10 clk = ~clk;

    logic                enable = 1'b0;
    logic [2:0]          os_sel = 3'd0;
    logic [NUM_CH-1:0]   ch_mask = '0;
    logic [15:0]         ad_data = 16'h0000;
    logic                ad_busy = 1'b0;
    logic                first_data = 1'b0;
    logic                m_ready = 1'b0;
    logic [2:0]          ad_os;
    logic                ad_cs, ad_rd, ad_reset, ad_convstab;
    logic [31:0]         m_data;
    logic                m_valid;
    logic [FIFO_AW:0]    fifo_level;
    logic [15:0]         overflow_cnt;
    logic                frame_err;
    ad_cap_state_e       dbg_state;

    ad_capture_pack #(
        .NUM_CH    (NUM_CH),
        .FIFO_AW   (FIFO_AW),
        .CONV_DIV  (CONV_DIV),
        .T_RD_LOW  (T_RD_LOW),
        .T_RD_HIGH (T_RD_HIGH),
        .BUSY_TO   (BUSY_TO)
    ) dut (
        .clk          (clk),
        .reset_syn    (reset_syn),
        .enable       (enable),
        .os_sel       (os_sel),
        .ch_mask      (ch_mask),
        .ad_data      (ad_data),
        .ad_busy      (ad_busy),
        .first_data   (first_data),
        .ad_os        (ad_os),
        .ad_cs        (ad_cs),
        .ad_rd        (ad_rd),
        .ad_reset     (ad_reset),
        .ad_convstab  (ad_convstab),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .frame_err    (frame_err),
        .dbg_state_o  (dbg_state)
    );

    // Checking
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Converter model: busy pulses 6 cycles starting 2 cycles after convst
    // falls; channel i drives data i+1 on each ad_rd falling edge.
    logic busy_en = 1'b1;
    logic fd_bad  = 1'b0;
    logic prev_cv = 1'b1;
    logic prev_rd = 1'b1;
    int   bcnt = 0;
    int   rd_idx = 0;

    always @(negedge clk) begin
        if (prev_cv && !ad_convstab) bcnt = 1;
        else if (bcnt > 0) bcnt = bcnt + 1;
        if (bcnt >= 9) bcnt = 0;
        ad_busy = busy_en && (bcnt >= 3);
        prev_cv = ad_convstab;
        if (ad_cs) begin
            rd_idx = 0;
        end else if (prev_rd && !ad_rd) begin
            ad_data    = 16'(rd_idx + 1);
            first_data = (rd_idx == 0) && !fd_bad;
            rd_idx++;
        end
        prev_rd = ad_rd;
    end

    // Scoreboard: every accepted stream word is matched against exp_q.
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    int cs_run = 0;
    int last_cs_run = 0;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_w = exp_q.pop_front();
                check("m_data", m_data, exp_w);
            end
        end
        if (!ad_cs) cs_run++;
        else if (cs_run != 0) begin
            last_cs_run = cs_run;
            cs_run = 0;
        end
    end

    // Driver tasks
    int k;
    int k2;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] mask);
        ch_mask = mask;
        enable  = 1'b1;
        for (k = 0; k < 300 && exp_q.size() != 0; k++) cyc(1);
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        enable = 1'b0;
        cyc(3);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        cyc(3);
        check("rst_cs", ad_cs, 1);
        check("rst_rd", ad_rd, 1);
        check("rst_convst", ad_convstab, 1);
        check("rst_adreset", ad_reset, 1);
        check("rst_os", ad_os, 0);
        check("rst_valid", m_valid, 0);
        check("rst_mdata", m_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_ferr", frame_err, 0);
        reset_syn = 1'b0;
        k2 = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!ad_reset) break;
            k2++;
        end
        check("rst_pulse_len", k2, 4);
        cyc(1);

        // Full mask, ramp data
        m_ready = 1'b1;
        os_sel  = 3'd3;
        exp_q.push_back(32'hA500FF08);
        exp_q.push_back(32'h00020001);
        exp_q.push_back(32'h00040003);
        exp_q.push_back(32'h00060005);
        exp_q.push_back(32'h00080007);
        run_frame("ff", 8'hFF);
        check("ad_os", ad_os, 3);
        check("cs_low_len", last_cs_run, 40);
        check("ff_level", fifo_level, 0);

        // Sparse masks, even and odd sample counts
        exp_q.push_back(32'hA5010502);
        exp_q.push_back(32'h00030001);
        run_frame("m05", 8'h05);
        exp_q.push_back(32'hA5020703);
        exp_q.push_back(32'h00020001);
        exp_q.push_back(32'h00000003);
        run_frame("m07", 8'h07);

        // first_data missing at channel 0
        fd_bad  = 1'b1;
        ch_mask = 8'hFF;
        enable  = 1'b1;
        for (k = 0; k < 300 && !frame_err; k++) cyc(1);
        check("fd_ferr", frame_err, 1);
        check("fd_state", dbg_state, ST_IDLE);
        enable = 1'b0;
        cyc(5);
        fd_bad = 1'b0;
        check("fd_level", fifo_level, 0);
        check("fd_valid", m_valid, 0);
        exp_q.push_back(32'hA5030101);
        exp_q.push_back(32'h00000001);
        run_frame("after_fd", 8'h01);

        // Reset during READ with words stored
        m_ready = 1'b0;
        ch_mask = 8'hFF;
        enable  = 1'b1;
        for (k = 0; k < 300 && fifo_level != 5; k++) cyc(1);
        check("held_level", fifo_level, 5);
        ch_mask = 8'h01;
        for (k = 0; k < 200 && ad_cs; k++) cyc(1);
        check("second_read", ad_cs, 0);
        cyc(6);
        reset_syn = 1'b1;
        cyc(1);
        check("mid_rst_cs", ad_cs, 1);
        check("mid_rst_rd", ad_rd, 1);
        check("mid_rst_adreset", ad_reset, 1);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_mdata", m_data, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_os", ad_os, 0);
        enable    = 1'b0;
        m_ready   = 1'b1;
        reset_syn = 1'b0;
        cyc(10);

        // ad_busy never rises
        busy_en = 1'b0;
        ch_mask = 8'hFF;
        enable  = 1'b1;
        for (k = 0; k < 300 && ad_convstab; k++) @(negedge clk);
        check("to_convst", ad_convstab, 0);
        for (k = 0; k < 10 && !ad_convstab; k++) @(negedge clk);
        k2 = 1;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ad_reset) break;
            k2++;
        end
        check("to_rise_len", k2, 16);
        k2 = 1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!ad_reset) break;
            k2++;
        end
        check("to_reset_len", k2, 4);
        enable = 1'b0;
        check("to_ferr", frame_err, 1);
        check("to_level", fifo_level, 0);
        busy_en = 1'b1;
        cyc(10);

        // Overflow with a stalled sink
        m_ready = 1'b0;
        ch_mask = 8'hFF;
        exp_q.push_back(32'hA500FF08);
        exp_q.push_back(32'h00020001);
        exp_q.push_back(32'h00040003);
        exp_q.push_back(32'h00060005);
        exp_q.push_back(32'h00080007);
        enable = 1'b1;
        for (k = 0; k < 400 && overflow_cnt != 2; k++) cyc(1);
        enable = 1'b0;
        check("ovf_cnt", overflow_cnt, 2);
        check("ovf_level", fifo_level, 5);
        check("ovf_valid", m_valid, 1);
        m_ready = 1'b1;
        for (k = 0; k < 50 && exp_q.size() != 0; k++) cyc(1);
        check("ovf_left", 32'(exp_q.size()), 32'd0);
        cyc(2);

        // Empty mask: nothing happens
        ch_mask = 8'h00;
        enable  = 1'b1;
        k2 = 0;
        for (k = 0; k < 250; k++) begin
            @(negedge clk);
            if (!ad_convstab) k2++;
        end
        enable = 1'b0;
        cyc(2);
        check("zero_conv", k2, 0);
        check("zero_ovf", overflow_cnt, 2);
        check("zero_level", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
